// File: rtl/pe_mem_sched_pkg.sv
// Shared definitions for the PE-to-IFM-memory read scheduler: limits, width helper
// and the return-tag layout {valid, bcast, id}.
package pe_mem_sched_pkg;

   localparam int N_MAX   = 16;
   localparam int LAT_MAX = 4;

   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((32'sd1 << w) < value) begin
         w = w + 32'sd1;
      end
      return w;
   endfunction

   localparam int ID_W_MAX = clog2(N_MAX);

   // Flag half of the return tag; the id field follows with a per-instance width.
   typedef struct packed {
      logic valid;
      logic bcast;
   } tag_flags_t;

endpackage

// File: rtl/pe_mem_sched_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// scanning upward modulo N.
module rr_pick
   import pe_mem_sched_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = clog2(N)
) (
   input  logic [N-1:0]    eligible,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    onehot,
   output logic [ID_W-1:0] idx,
   output logic            any
);

   logic [N-1:0]    rot_s;
   logic [ID_W-1:0] off_s;
   logic [ID_W:0]   sum_s;

   // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
   always_comb begin
      rot_s = N'({eligible, eligible} >> ptr);
      off_s = {ID_W{1'b0}};
      for (int j = N - 1; j >= 0; j--) begin
         off_s = rot_s[j] ? ID_W'(j) : off_s;
      end
      sum_s  = {1'b0, ptr} + {1'b0, off_s};
      idx    = (sum_s >= (ID_W+1)'(N)) ? ID_W'(sum_s - (ID_W+1)'(N)) : sum_s[ID_W-1:0];
      any    = |eligible;
      onehot = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : {N{1'b0}};
   end

endmodule

// File: rtl/pe_mem_sched.sv
// Shares the IFM memory read port among N PEs: round-robin issue, broadcast merge
// and a read-latency tag pipe. Optional counters under PE_MEM_SCHED_STATS_EN.
module pe_mem_sched
   import pe_mem_sched_pkg::*;
#(
   parameter int N        = 4,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic [N*ADDR_W-1:0]   adr,
   input  logic                  bcast_en,
   input  logic                  hold,
   output logic [N-1:0]          grant,
   output logic                  mem_re,
   output logic [ADDR_W-1:0]     mem_adr,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  rd_valid,
   output logic                  rd_bcast,
   output logic [clog2(N)-1:0]   rd_id,
   output logic [DATA_W-1:0]     rd_data
`ifdef PE_MEM_SCHED_STATS_EN
   ,
   output logic [N*16-1:0]       grant_cnt,
   output logic [15:0]           bcast_cnt
`endif
);

   localparam int ID_W = clog2(N);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

   logic [N-1:0]      eligible_s, pick_oh_s, grant_d;
   logic [ID_W-1:0]   pick_idx_s, rr_ptr_r, rr_ptr_d, iss_id_r, iss_id_d;
   logic              pick_any_s, all_same_s, issue_bc_s, issue_norm_s;
   logic              mem_re_d, iss_bcast_r, iss_bcast_d;
   logic [ADDR_W-1:0] adr0_s, pick_adr_s, mem_adr_d;
   tag_flags_t        pipe_flags_r [READ_LAT];
   logic [ID_W-1:0]   pipe_id_r    [READ_LAT];

   rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
      .eligible (eligible_s),
      .ptr      (rr_ptr_r),
      .onehot   (pick_oh_s),
      .idx      (pick_idx_s),
      .any      (pick_any_s)
   );

   // Eligibility, broadcast detect and next issue state.
   always_comb begin
      eligible_s = req & ~grant;
      adr0_s     = adr[ADDR_W-1:0];
      all_same_s = 1'b1;
      pick_adr_s = adr0_s;
      for (int i = 0; i < N; i++) begin
         all_same_s = all_same_s & (adr[i*ADDR_W +: ADDR_W] == adr0_s);
         pick_adr_s = pick_oh_s[i] ? adr[i*ADDR_W +: ADDR_W] : pick_adr_s;
      end
      issue_bc_s   = ~hold & bcast_en & (&eligible_s) & all_same_s;
      issue_norm_s = ~hold & pick_any_s & ~issue_bc_s;

      grant_d     = {N{1'b0}};
      mem_re_d    = 1'b0;
      mem_adr_d   = mem_adr;
      rr_ptr_d    = rr_ptr_r;
      iss_bcast_d = 1'b0;
      iss_id_d    = {ID_W{1'b0}};
      // A broadcast serves every PE with one read and leaves the rotation untouched.
      if (issue_bc_s) begin
         grant_d     = {N{1'b1}};
         mem_re_d    = 1'b1;
         mem_adr_d   = adr0_s;
         iss_bcast_d = 1'b1;
      end else if (issue_norm_s) begin
         grant_d   = pick_oh_s;
         mem_re_d  = 1'b1;
         mem_adr_d = pick_adr_s;
         iss_id_d  = pick_idx_s;
         rr_ptr_d  = (pick_idx_s == LAST_ID) ? {ID_W{1'b0}} : pick_idx_s + ID_W'(1);
      end else begin
         mem_re_d = 1'b0;
      end
   end

   // Issue registers, then the read-latency tag pipe aligned with mem_rdata.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant       <= {N{1'b0}};
         mem_re      <= 1'b0;
         mem_adr     <= {ADDR_W{1'b0}};
         rr_ptr_r    <= {ID_W{1'b0}};
         iss_bcast_r <= 1'b0;
         iss_id_r    <= {ID_W{1'b0}};
         for (int k = 0; k < READ_LAT; k++) begin
            pipe_flags_r[k] <= tag_flags_t'(2'b00);
            pipe_id_r[k]    <= {ID_W{1'b0}};
         end
      end else begin
         grant       <= grant_d;
         mem_re      <= mem_re_d;
         mem_adr     <= mem_adr_d;
         rr_ptr_r    <= rr_ptr_d;
         iss_bcast_r <= iss_bcast_d;
         iss_id_r    <= iss_id_d;
         pipe_flags_r[0] <= '{valid: mem_re, bcast: iss_bcast_r};
         pipe_id_r[0]    <= iss_id_r;
         for (int k = 1; k < READ_LAT; k++) begin
            pipe_flags_r[k] <= pipe_flags_r[k-1];
            pipe_id_r[k]    <= pipe_id_r[k-1];
         end
      end
   end

   assign rd_valid = pipe_flags_r[READ_LAT-1].valid;
   assign rd_bcast = pipe_flags_r[READ_LAT-1].bcast;
   assign rd_id    = pipe_id_r[READ_LAT-1];
   assign rd_data  = mem_rdata;

`ifdef PE_MEM_SCHED_STATS_EN
   // Saturating per-PE normal-grant and broadcast-issue counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= {(N*16){1'b0}};
         bcast_cnt <= 16'h0000;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (issue_norm_s && pick_oh_s[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'h0001;
            end
         end
         if (issue_bc_s && (bcast_cnt != 16'hFFFF)) begin
            bcast_cnt <= bcast_cnt + 16'h0001;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pe_mem_sched.sv
// Bench for pe_mem_sched (N=4, READ_LAT=1): directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_pe_mem_sched;

   localparam int N   = 4;
   localparam int AW  = 7;
   localparam int DW  = 32;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*AW-1:0] adr;
   logic          bcast_en, hold;
   logic [N-1:0]  grant;
   logic          mem_re;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_rdata = 32'hDEADBEEF;
   logic          rd_valid, rd_bcast;
   logic [1:0]    rd_id;
   logic [DW-1:0] rd_data;

   int n_cmp = 0;
   int n_bad = 0;
   bit auto_drop;

   pe_mem_sched #(.N(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .adr(adr), .bcast_en(bcast_en), .hold(hold),
      .grant(grant), .mem_re(mem_re), .mem_adr(mem_adr), .mem_rdata(mem_rdata),
      .rd_valid(rd_valid), .rd_bcast(rd_bcast), .rd_id(rd_id), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   // Memory: one-cycle read returning address + 100.
   always @(posedge clk) begin
      mem_rdata <= mem_re ? (32'(mem_adr) + 32'd100) : 32'hDEADBEEF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int adr_of(input int i);
      return int'(adr[i*AW +: AW]);
   endfunction

   // Reference model
   typedef struct { int due; bit bc; int id; int adr; } ret_t;
   ret_t q[$];
   int cyc = 0;
   int ptr = 0;
   bit started = 1'b0;
   logic [N-1:0]  exp_grant = '0;
   logic          exp_mem_re = 1'b0;
   logic [AW-1:0] exp_mem_adr = '0;

   always @(posedge clk) begin
      logic [N-1:0] elig;
      bit same;
      int win;
      ret_t r;
      cyc++;
      if (rst) begin
         exp_grant = '0; exp_mem_re = 1'b0; exp_mem_adr = '0; ptr = 0;
         q.delete();
         started = 1'b1;
      end else begin
         elig = req & ~exp_grant;
         same = 1'b1;
         for (int i = 0; i < N; i++) if (adr_of(i) != adr_of(0)) same = 1'b0;
         exp_grant = '0;
         exp_mem_re = 1'b0;
         if (!hold && elig != 0) begin
            exp_mem_re = 1'b1;
            r.due = cyc + LAT;
            if (bcast_en && elig == 4'hF && same) begin
               exp_grant = 4'hF;
               r.bc = 1'b1; r.id = 0; r.adr = adr_of(0);
            end else begin
               win = -1;
               for (int k = 0; k < N; k++)
                  if (win < 0 && elig[(ptr + k) % N]) win = (ptr + k) % N;
               exp_grant = 4'(1 << win);
               ptr = (win + 1) % N;
               r.bc = 1'b0; r.id = win; r.adr = adr_of(win);
            end
            exp_mem_adr = 7'(r.adr);
            q.push_back(r);
         end
      end
      #1;
      if (started) begin
         check("grant", grant, exp_grant);
         check("mem_re", mem_re, exp_mem_re);
         check("mem_adr", mem_adr, exp_mem_adr);
         if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            check("rd_valid", rd_valid, 1);
            check("rd_bcast", rd_bcast, r.bc);
            check("rd_id", rd_id, r.id);
            check("rd_data", rd_data, r.adr + 100);
         end else begin
            check("rd_valid_idle", rd_valid, 0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
      if (auto_drop) req = req & ~exp_grant;
   endtask

   initial begin
      int re_cnt;
      logic [N-1:0] acc;
      rst = 1'b1; req = '0; adr = '0; bcast_en = 1'b0; hold = 1'b0; auto_drop = 1'b1;
      step(); step();
      check("rst_grant", grant, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_adr", mem_adr, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_bcast", rd_bcast, 0);
      check("rst_rd_id", rd_id, 0);
      rst = 1'b0;

      // single request
      req = 4'b0010; adr[1*AW +: AW] = 7'd9;
      step();
      check("t1_grant", grant, 4'b0010);
      check("t1_mem_adr", mem_adr, 9);
      step();
      check("t1_rd_valid", rd_valid, 1);
      check("t1_rd_id", rd_id, 1);
      check("t1_rd_data", rd_data, 109);

      // all four continuously
      rst = 1'b1; step(); rst = 1'b0;
      auto_drop = 1'b0; req = 4'hF;
      for (int i = 0; i < N; i++) adr[i*AW +: AW] = 7'(i * 10 + 1);
      for (int k = 1; k <= 5; k++) begin
         step();
         check("t2_grant", grant, 1 << ((k - 1) % 4));
         if (k >= 2) begin
            check("t2_rd_valid", rd_valid, 1);
            check("t2_rd_id", rd_id, (k - 2) % 4);
            check("t2_rd_data", rd_data, ((k - 2) % 4) * 10 + 101);
         end
      end
      req = '0; auto_drop = 1'b1;
      step(); step();

      // broadcast
      bcast_en = 1'b1; req = 4'hF;
      for (int i = 0; i < N; i++) adr[i*AW +: AW] = 7'd20;
      re_cnt = 0;
      step();
      re_cnt += int'(mem_re);
      check("t3_grant", grant, 4'hF);
      check("t3_mem_adr", mem_adr, 20);
      step();
      re_cnt += int'(mem_re);
      check("t3_rd_bcast", rd_bcast, 1);
      check("t3_rd_data", rd_data, 120);
      step();
      re_cnt += int'(mem_re);
      check("t3_re_count", re_cnt, 1);

      // broadcast enabled, mismatched address
      req = 4'hF; adr[2*AW +: AW] = 7'd21; acc = '0;
      for (int k = 0; k < 5; k++) begin
         step();
         acc = acc | grant;
         if (k < 4) check("t4_onehot", $countones(grant), 1);
         check("t4_rd_bcast", rd_bcast, 0);
      end
      check("t4_all_served", acc, 4'hF);

      // hold
      bcast_en = 1'b0; req = 4'b0001; adr[0 +: AW] = 7'd5;
      step();
      check("t5_grant", grant, 4'b0001);
      hold = 1'b1; req = req | 4'b1110;
      step();
      check("t5_rd_valid", rd_valid, 1);
      check("t5_rd_data", rd_data, 105);
      check("t5_held_grant", grant, 0);
      step();
      check("t5_held_re", mem_re, 0);
      hold = 1'b0;
      step();
      check("t5_release_grant", grant, 4'b0010);

      // reset right after an issue
      step();
      check("t6_mem_re", mem_re, 1);
      rst = 1'b1;
      step();
      check("t6_rd_valid", rd_valid, 0);
      check("t6_grant", grant, 0);
      rst = 1'b0; req = 4'hF;
      step();
      check("t6_first_grant", grant, 4'b0001);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         hold = ($urandom_range(0, 7) == 0) || ((c % 64) < 5);
         bcast_en = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               adr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(20 + $urandom_range(0, 1));
            end
         end
         step();
      end
      rst = 1'b0; hold = 1'b0; req = '0;
      for (int k = 0; k < 6; k++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
